multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM of the multicycle datapath; sits directly upstream of the PC, IR, MDR and register-file registers.
//  Decodes IR opcode and sequences FETCH/DECODE/EXECUTE/MEM/WB states.
//  Drives write enables (PCWrite, IRWrite, RegWrite, ...) and mux selects consumed by those registers.
//  Stalls in memory states on a MemReady handshake.
// PARAMETERS
//  OPCODE_WIDTH  6  width of Opcode input (IR[31:26])
//  MEM_HANDSHAKE 1  1: memory states wait for MemReady; 0: MemReady ignored (treated as 1)
// PORTS
//  Clk          in   1  rising-edge clock
//  Reset        in   1  asynchronous, active-low reset
//  Opcode       in   6  IR[31:26], sampled in DECODE and MEMADR only
//  MemReady     in   1  memory completes current access this cycle
//  PCWrite      out  1  unconditional PC write enable
//  PCWriteCond  out  1  PC write enable qualified by ALU Zero (beq)
//  IorD         out  1  mem address select: 0=PC, 1=ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  instruction register write enable
//  MemtoReg     out  1  reg write data: 0=ALUOut, 1=MDR
//  RegDst       out  1  reg write addr: 0=rt, 1=rd
//  RegWrite     out  1  register file write enable
//  ALUSrcA      out  1  0=PC, 1=A
//  ALUSrcB      out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
//  ALUOp        out  2  00=add, 01=sub, 10=funct-decoded
//  PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//  IllegalOp    out  1  one-cycle pulse: unknown opcode seen in DECODE
//  State        out  4  current state, for debug/test
// BEHAVIOUR
//  - Reset low: State=FETCH immediately; every output above forced 0 while Reset low (no writes).
//  - Outputs are Moore-decoded from State, except IRWrite/PCWrite in FETCH = MemReady (Mealy qualifier).
//  - Any signal not listed for a state is 0. States (4-bit encoding):
//    FETCH(0):   MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady;
//                stay until MemReady, then DECODE
//    DECODE(1):  ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute); next by Opcode:
//                lw 100011/sw 101011 -> MEMADR; R 000000 -> EXEC; beq 000100 -> BRANCH;
//                j 000010 -> JUMP; addi 001000 -> ADDIEX; else -> FETCH with IllegalOp=1
//    MEMADR(2):  ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD (lw) or MEMWR (sw)
//    MEMRD(3):   MemRead, IorD=1; stay until MemReady -> MEMWB
//    MEMWB(4):   RegWrite, RegDst=0, MemtoReg=1 -> FETCH
//    MEMWR(5):   MemWrite, IorD=1; stay until MemReady -> FETCH
//    EXEC(6):    ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RTYPEWB
//    RTYPEWB(7): RegWrite, RegDst=1, MemtoReg=0 -> FETCH
//    BRANCH(8):  ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01 -> FETCH
//    JUMP(9):    PCWrite, PCSource=10 -> FETCH
//    ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB
//    ADDIWB(11): RegWrite, RegDst=0, MemtoReg=0 -> FETCH
//  - Encodings 12-15 unreachable; if entered, next state FETCH, all outputs 0.
//  - Cycle counts at MemReady=1 every cycle: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
//  - MemRead/MemWrite held constant while waiting; MemReady outside FETCH/MEMRD/MEMWR ignored.
//  - Reset asserted mid-instruction: abort at once; resume at FETCH after release; no partial writes.
//  - Opcode changes while in states other than DECODE/MEMADR have no effect.
// STRUCTURE
//  - Package multicycle_pkg: state encodings, opcode constants, ALUOp/ALUSrcB/PCSource codes.
//  - Single module, no sub-module: 4-bit state register with async reset, next-state case,
//    output decode case.
// TESTING
//  1 Reset low mid-MEMRD -> State=0, all enables 0 same cycle; release -> FETCH, MemRead=1.
//  2 lw (100011), MemReady=1 -> states 0,1,2,3,4,0; RegWrite=1, MemtoReg=1 only in state 4.
//  3 sw, MemReady low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, no RegWrite, then FETCH.
//  4 FETCH with MemReady=0 for 2 cycles -> IRWrite=PCWrite=0; 1 on ready cycle; then DECODE.
//  5 beq then j -> BRANCH: PCWriteCond=1, PCSource=01; JUMP: PCWrite=1, PCSource=10; 3 cycles each.
//  6 Opcode 111111 in DECODE -> IllegalOp=1 one cycle, next FETCH, no RegWrite/MemWrite.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_pkg
//  Description : State encodings, opcode constants and datapath select codes
//                shared by the multicycle control FSM and its interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Control bundle between the multicycle control FSM (master)
//                and the datapath registers/memory it sequences (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
    parameter int OPCODE_WIDTH = 6
);
    logic [OPCODE_WIDTH-1:0] Opcode;
    logic                    MemReady;
    logic                    PCWrite;
    logic                    PCWriteCond;
    logic                    IorD;
    logic                    MemRead;
    logic                    MemWrite;
    logic                    IRWrite;
    logic                    MemtoReg;
    logic                    RegDst;
    logic                    RegWrite;
    logic                    ALUSrcA;
    logic [1:0]              ALUSrcB;
    logic [1:0]              ALUOp;
    logic [1:0]              PCSource;
    logic                    IllegalOp;
    logic [3:0]              State;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, IllegalOp, State
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, IllegalOp, State
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM of the multicycle datapath: sequences
//                FETCH/DECODE/EXECUTE/MEM/WB and drives enables and selects.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OPCODE_WIDTH  = 6,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    multicycle_control_if.master  bus
);

    state_e state_q;
    state_e state_d;
    logic   mem_ready;

    generate
        if (MEM_HANDSHAKE) begin : g_handshake
            assign mem_ready = bus.MemReady;
        end else begin : g_no_handshake
            assign mem_ready = 1'b1;
        end
    endgenerate

    logic is_lw, is_sw, is_rtype, is_beq, is_j, is_addi, opc_legal;

    assign is_lw     = (bus.Opcode == OPCODE_WIDTH'(OP_LW));
    assign is_sw     = (bus.Opcode == OPCODE_WIDTH'(OP_SW));
    assign is_rtype  = (bus.Opcode == OPCODE_WIDTH'(OP_RTYPE));
    assign is_beq    = (bus.Opcode == OPCODE_WIDTH'(OP_BEQ));
    assign is_j      = (bus.Opcode == OPCODE_WIDTH'(OP_J));
    assign is_addi   = (bus.Opcode == OPCODE_WIDTH'(OP_ADDI));
    assign opc_legal = is_lw | is_sw | is_rtype | is_beq | is_j | is_addi;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_lw || is_sw)  state_d = S_MEMADR;
                else if (is_rtype)   state_d = S_EXEC;
                else if (is_beq)     state_d = S_BRANCH;
                else if (is_j)       state_d = S_JUMP;
                else if (is_addi)    state_d = S_ADDIEX;
                else                 state_d = S_FETCH;
            end
            S_MEMADR:  state_d = is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC:    state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    // Decode is gated by Reset so no enable can fire while reset is held.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        illegal_op    = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        if (Reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = SRCB_IMM_SH;
                    illegal_op = ~opc_legal;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_RTYPEWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                S_ADDIWB:  reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = iord;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.PCSource    = pc_source;
    assign bus.IllegalOp   = illegal_op;
    assign bus.State       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control against a
//                per-instruction state-path model with memory wait stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_WIDTH(6)) bus ();

    multicycle_control #(
        .OPCODE_WIDTH  (6),
        .MEM_HANDSHAKE (1'b1)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus.master)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,IllegalOp}
    function automatic logic [16:0] exp_out(input int st, input bit rdy, input bit ill);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, il;
        logic [1:0] sb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, il} = '0;
        sb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin sb = 2'b11; il = ill; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, pcs, il};
    endfunction

    function automatic logic [16:0] dut_out();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.IllegalOp};
    endfunction

    // Called 1 time unit after a rising edge with the DUT expected in FETCH.
    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                             input bit rnd, output int cycles, output int mw_cnt,
                             output int rw_cnt, output int ill_cnt);
        int  path[$];
        int  idx, fs, ms, st;
        bit  rdy, legal, waits;
        legal = 1'b1;
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b000100: path = '{0, 1, 8};
            6'b000010: path = '{0, 1, 9};
            6'b001000: path = '{0, 1, 10, 11};
            default: begin path = '{0, 1}; legal = 1'b0; end
        endcase
        idx = 0; fs = fstall; ms = mstall;
        cycles = 0; mw_cnt = 0; rw_cnt = 0; ill_cnt = 0;
        while (idx < path.size()) begin
            st    = path[idx];
            waits = (st == 0) || (st == 3) || (st == 5);
            if (waits && st == 0 && fs > 0) begin
                rdy = 1'b0; fs--;
            end else if (waits && st != 0 && ms > 0) begin
                rdy = 1'b0; ms--;
            end else if (waits) begin
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            bus.MemReady = rdy;
            bus.Opcode   = (st == 1 || st == 2) ? op : 6'($urandom);
            @(negedge clk);
            cycles++;
            n_cmp++;
            if (bus.State !== 4'(st)) begin
                n_err++;
                $display("FAIL state op=%b cyc=%0d: got %0d expected %0d", op, cycles, bus.State, st);
            end
            n_cmp++;
            if (dut_out() !== exp_out(st, rdy, !legal)) begin
                n_err++;
                $display("FAIL outputs op=%b st=%0d: got %b expected %b", op, st, dut_out(), exp_out(st, rdy, !legal));
            end
            mw_cnt  += int'(bus.MemWrite);
            rw_cnt  += int'(bus.RegWrite);
            ill_cnt += int'(bus.IllegalOp);
            if (!waits || rdy) idx++;
            @(posedge clk);
            #1;
            if (cycles > 300) begin
                n_cmp++; n_err++;
                $display("FAIL budget op=%b: got %0d cycles expected completion", op, cycles);
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.MemReady = 1'b1;
        bus.Opcode   = 6'b100011;
        @(negedge clk);
        n_cmp++;
        if ({bus.State, dut_out()} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_hold: got %b expected all zero", {bus.State, dut_out()});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.MemReady = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.State, dut_out()} !== {4'd0, exp_out(0, 1'b0, 1'b0)}) begin
            n_err++;
            $display("FAIL reset_release: got %b expected %b", {bus.State, dut_out()}, {4'd0, exp_out(0, 1'b0, 1'b0)});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        int c, mw, rw, il;
        run_instr(6'b100011, 0, 0, 1'b0, c, mw, rw, il);
        n_cmp++;
        if (c !== 5 || rw !== 1) begin
            n_err++;
            $display("FAIL lw_len: got cycles=%0d regwrites=%0d expected 5/1", c, rw);
        end
    endtask

    task automatic test_sw_stall();
        int c, mw, rw, il;
        run_instr(6'b101011, 0, 3, 1'b0, c, mw, rw, il);
        n_cmp++;
        if (c !== 7 || mw !== 4 || rw !== 0) begin
            n_err++;
            $display("FAIL sw_stall: got cycles=%0d memwrites=%0d regwrites=%0d expected 7/4/0", c, mw, rw);
        end
    endtask

    task automatic test_fetch_stall();
        int c, mw, rw, il;
        run_instr(6'b000000, 2, 0, 1'b0, c, mw, rw, il);
        n_cmp++;
        if (c !== 6 || rw !== 1) begin
            n_err++;
            $display("FAIL fetch_stall: got cycles=%0d regwrites=%0d expected 6/1", c, rw);
        end
    endtask

    task automatic test_branch_jump();
        int c, mw, rw, il;
        run_instr(6'b000100, 0, 0, 1'b0, c, mw, rw, il);
        n_cmp++;
        if (c !== 3) begin
            n_err++;
            $display("FAIL beq_len: got %0d expected 3", c);
        end
        run_instr(6'b000010, 0, 0, 1'b0, c, mw, rw, il);
        n_cmp++;
        if (c !== 3) begin
            n_err++;
            $display("FAIL j_len: got %0d expected 3", c);
        end
        run_instr(6'b001000, 0, 0, 1'b0, c, mw, rw, il);
        n_cmp++;
        if (c !== 4 || rw !== 1) begin
            n_err++;
            $display("FAIL addi_len: got cycles=%0d regwrites=%0d expected 4/1", c, rw);
        end
    endtask

    task automatic test_illegal();
        int c, mw, rw, il;
        run_instr(6'b111111, 0, 0, 1'b0, c, mw, rw, il);
        n_cmp++;
        if (c !== 2 || il !== 1 || mw !== 0 || rw !== 0) begin
            n_err++;
            $display("FAIL illegal: got cycles=%0d ill=%0d mw=%0d rw=%0d expected 2/1/0/0", c, il, mw, rw);
        end
    endtask

    task automatic test_reset_mid_memrd();
        int c, mw, rw, il;
        bus.Opcode = 6'b100011;
        bus.MemReady = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.MemReady = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.State !== 4'd3 || bus.MemRead !== 1'b1) begin
            n_err++;
            $display("FAIL memrd_entry: got state=%0d memread=%b expected 3/1", bus.State, bus.MemRead);
        end
        @(posedge clk); #1;
        bus.MemReady = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.State, dut_out()} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_abort: got %b expected all zero", {bus.State, dut_out()});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.MemReady = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.State, dut_out()} !== {4'd0, exp_out(0, 1'b0, 1'b0)}) begin
            n_err++;
            $display("FAIL reset_resume: got %b expected %b", {bus.State, dut_out()}, {4'd0, exp_out(0, 1'b0, 1'b0)});
        end
        @(posedge clk); #1;
        run_instr(6'b000000, 0, 0, 1'b0, c, mw, rw, il);
    endtask

    task automatic test_random();
        logic [5:0] ops[7];
        logic [5:0] op;
        int c, mw, rw, il;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b110011};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b110011) op = 6'b111000 | 6'($urandom_range(1, 7));
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, c, mw, rw, il);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.MemReady = 1'b0;
        bus.Opcode   = '0;
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_fetch_stall();
        test_branch_jump();
        test_illegal();
        test_reset_mid_memrd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
